// File: rtl/scheduler_sched_info_ctrl_if.sv
// Client-facing bus of the schedule-info controller.
// It groups the store, completion-clear, read-request and read-response channels.
interface scheduler_sched_info_ctrl_if #(
  parameter int MAX_ACCS = 16,
  parameter int NUM_RD   = 4
);
  localparam int AW = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1;
  localparam int IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [AW-1:0]        wr_addr;
  logic [49:0]          wr_data;
  logic                 clr_valid;
  logic [AW-1:0]        clr_addr;
  logic [NUM_RD-1:0]    rd_req_valid;
  logic [NUM_RD-1:0]    rd_req_ready;
  logic [NUM_RD*AW-1:0] rd_req_addr;
  logic                 rd_resp_valid;
  logic [IW-1:0]        rd_resp_id;
  logic [49:0]          rd_resp_data;
  logic                 rd_resp_hit;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_valid, clr_addr, rd_req_valid, rd_req_addr,
    input  wr_ready, rd_req_ready, rd_resp_valid, rd_resp_id, rd_resp_data, rd_resp_hit
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_valid, clr_addr, rd_req_valid, rd_req_addr,
    output wr_ready, rd_req_ready, rd_resp_valid, rd_resp_id, rd_resp_data, rd_resp_hit
  );
endinterface

// File: rtl/scheduler_sched_info_ctrl.sv
// Schedule-info memory controller.
// Port A takes stores from dispatch. Port B is shared by the read clients through a
// round-robin arbiter. A per-slot valid bitmap is kept here. A store to the slot being
// read in the same cycle is forwarded into the response, because the memory is read-first.
module scheduler_sched_info_ctrl #(
  parameter int MAX_ACCS = 16,
  parameter int NUM_RD   = 4,
  localparam int AW = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1,
  localparam int IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  scheduler_sched_info_ctrl_if.slave bus,
  output logic [MAX_ACCS-1:0] valid_bitmap,
  output logic [AW-1:0]       scheduleData_portA_addr,
  output logic                scheduleData_portA_en,
  output logic [49:0]         scheduleData_portA_din,
  output logic [AW-1:0]       scheduleData_portB_addr,
  output logic                scheduleData_portB_en,
  input  logic [49:0]         scheduleData_portB_dout
);

  // run_r holds the interface quiet until the first edge after reset release.
  logic                run_r;
  logic [IW-1:0]       ptr_r;
  logic [MAX_ACCS-1:0] bitmap_r;
  logic [MAX_ACCS-1:0] bitmap_nxt_s;

  logic                wr_fire_s;
  logic                wr_in_s;
  logic                clr_in_s;

  logic                gnt_found_s;
  logic [IW-1:0]       gnt_idx_s;
  logic [NUM_RD-1:0]   gnt_onehot_s;
  logic [AW-1:0]       gnt_addr_s;
  logic                gnt_in_s;
  int                  idx_s;

  logic                resp_valid_r;
  logic [IW-1:0]       resp_id_r;
  logic                resp_hit_r;
  logic                resp_oor_r;
  logic                resp_byp_r;
  logic [49:0]         byp_data_r;

  assign wr_fire_s = bus.wr_valid & run_r;
  assign wr_in_s   = (32'(bus.wr_addr) < MAX_ACCS);
  assign clr_in_s  = (32'(bus.clr_addr) < MAX_ACCS);

  // Round-robin search: the first requester after the last granted index wins.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    idx_s       = 0;
    for (int k = 1; k <= NUM_RD; k++) begin
      idx_s = (int'(ptr_r) + k) % NUM_RD;
      if (!gnt_found_s && run_r && bus.rd_req_valid[idx_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = IW'(idx_s);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Decode the grant to a one-hot vector and select the address of the granted client.
  always_comb begin
    gnt_onehot_s = '0;
    gnt_addr_s   = bus.rd_req_addr[gnt_idx_s*AW +: AW];
    if (gnt_found_s) begin
      gnt_onehot_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_onehot_s = '0;
    end
  end

  assign gnt_in_s = (32'(gnt_addr_s) < MAX_ACCS);

  // Next bitmap: apply the clear first so that a store to the same slot wins.
  always_comb begin
    bitmap_nxt_s = bitmap_r;
    if (bus.clr_valid && run_r && clr_in_s) begin
      bitmap_nxt_s[bus.clr_addr] = 1'b0;
    end else begin
      bitmap_nxt_s = bitmap_nxt_s;
    end
    if (wr_fire_s && wr_in_s) begin
      bitmap_nxt_s[bus.wr_addr] = 1'b1;
    end else begin
      bitmap_nxt_s = bitmap_nxt_s;
    end
  end

  // Memory port drive. Address and data are zeroed when the port is idle.
  always_comb begin
    scheduleData_portA_en   = wr_fire_s & wr_in_s;
    scheduleData_portA_addr = '0;
    scheduleData_portA_din  = '0;
    scheduleData_portB_en   = gnt_found_s & gnt_in_s;
    scheduleData_portB_addr = '0;
    if (scheduleData_portA_en) begin
      scheduleData_portA_addr = bus.wr_addr;
      scheduleData_portA_din  = bus.wr_data;
    end else begin
      scheduleData_portA_addr = '0;
    end
    if (scheduleData_portB_en) begin
      scheduleData_portB_addr = gnt_addr_s;
    end else begin
      scheduleData_portB_addr = '0;
    end
  end

  // State and response pipeline registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_r        <= 1'b0;
      ptr_r        <= IW'(NUM_RD - 1);
      bitmap_r     <= '0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_hit_r   <= 1'b0;
      resp_oor_r   <= 1'b0;
      resp_byp_r   <= 1'b0;
      byp_data_r   <= '0;
    end else begin
      run_r        <= 1'b1;
      bitmap_r     <= bitmap_nxt_s;
      resp_valid_r <= gnt_found_s;
      if (gnt_found_s) begin
        ptr_r      <= gnt_idx_s;
        resp_id_r  <= gnt_idx_s;
        resp_hit_r <= gnt_in_s & bitmap_nxt_s[gnt_addr_s];
        resp_oor_r <= ~gnt_in_s;
        resp_byp_r <= gnt_in_s & wr_fire_s & wr_in_s & (bus.wr_addr == gnt_addr_s);
        byp_data_r <= bus.wr_data;
      end else begin
        ptr_r      <= ptr_r;
        resp_hit_r <= 1'b0;
        resp_oor_r <= 1'b0;
        resp_byp_r <= 1'b0;
      end
    end
  end

  // Response data: the forwarded store, the memory output, or zero when out of range.
  always_comb begin
    bus.rd_resp_data = '0;
    if (!resp_valid_r || resp_oor_r) begin
      bus.rd_resp_data = '0;
    end else if (resp_byp_r) begin
      bus.rd_resp_data = byp_data_r;
    end else begin
      bus.rd_resp_data = scheduleData_portB_dout;
    end
  end

  assign bus.wr_ready      = run_r;
  assign bus.rd_req_ready  = gnt_onehot_s;
  assign bus.rd_resp_valid = resp_valid_r;
  assign bus.rd_resp_id    = resp_id_r;
  assign bus.rd_resp_hit   = resp_hit_r;
  assign valid_bitmap      = bitmap_r;

endmodule

// File: tb/tb_scheduler_sched_info_ctrl.sv
// Directed bench for scheduler_sched_info_ctrl. It uses a 16-slot instance with a
// read-first memory model and a 12-slot instance to exercise out-of-range addresses.
module tb_scheduler_sched_info_ctrl;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  scheduler_sched_info_ctrl_if #(.MAX_ACCS(16), .NUM_RD(4)) bus ();
  scheduler_sched_info_ctrl_if #(.MAX_ACCS(12), .NUM_RD(4)) bus2 ();

  logic [15:0] bitmap;
  logic [3:0]  a_addr, b_addr;
  logic        a_en, b_en;
  logic [49:0] a_din;
  logic [49:0] b_dout;

  logic [11:0] bitmap2;
  logic [3:0]  a_addr2, b_addr2;
  logic        a_en2, b_en2;
  logic [49:0] a_din2;
  logic [49:0] b_dout2;

  logic [49:0] mem [16];
  logic        mem_clear;

  scheduler_sched_info_ctrl #(.MAX_ACCS(16), .NUM_RD(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .valid_bitmap(bitmap),
    .scheduleData_portA_addr(a_addr), .scheduleData_portA_en(a_en),
    .scheduleData_portA_din(a_din), .scheduleData_portB_addr(b_addr),
    .scheduleData_portB_en(b_en), .scheduleData_portB_dout(b_dout)
  );

  scheduler_sched_info_ctrl #(.MAX_ACCS(12), .NUM_RD(4)) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2), .valid_bitmap(bitmap2),
    .scheduleData_portA_addr(a_addr2), .scheduleData_portA_en(a_en2),
    .scheduleData_portA_din(a_din2), .scheduleData_portB_addr(b_addr2),
    .scheduleData_portB_en(b_en2), .scheduleData_portB_dout(b_dout2)
  );

  assign b_dout2 = 50'h3_FFFF_FFFF_FFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous memory model behind port A/B of the 16-slot instance.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 50'h0;
      b_dout <= 50'h0;
    end else begin
      if (b_en) b_dout <= mem[b_addr];
      if (a_en) mem[a_addr] <= a_din;
    end
  end

  task automatic idle_inputs();
    bus.wr_valid = 1'b0;  bus.wr_addr = 4'd0;  bus.wr_data = 50'h0;
    bus.clr_valid = 1'b0; bus.clr_addr = 4'd0;
    bus.rd_req_valid = 4'b0; bus.rd_req_addr = 16'h0;
    bus2.wr_valid = 1'b0; bus2.wr_addr = 4'd0; bus2.wr_data = 50'h0;
    bus2.clr_valid = 1'b0; bus2.clr_addr = 4'd0;
    bus2.rd_req_valid = 4'b0; bus2.rd_req_addr = 16'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 50'h55;
    bus.rd_req_valid = 4'b1111; bus.rd_req_addr = 16'h2222;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%0h exp=0", bus.wr_ready); end
    checks++; if (bus.rd_req_ready !== 4'b0) begin failures++; $display("FAIL reset_rd_req_ready got=%0h exp=0", bus.rd_req_ready); end
    checks++; if (a_en !== 1'b0 || b_en !== 1'b0) begin failures++; $display("FAIL reset_port_en got=%0b%0b exp=00", a_en, b_en); end
    checks++; if (bus.rd_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0h exp=0", bus.rd_resp_valid); end
    checks++; if (bitmap !== 16'h0) begin failures++; $display("FAIL reset_bitmap got=%0h exp=0", bitmap); end
    idle_inputs();
    @(negedge clk);
    mem_clear = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL post_reset_wr_ready got=%0h exp=1", bus.wr_ready); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 50'h1234;
    #1;
    checks++; if (a_en !== 1'b1 || a_addr !== 4'd3 || a_din !== 50'h1234) begin
      failures++; $display("FAIL wr_porta got en=%0b addr=%0d din=%0h exp en=1 addr=3 din=1234", a_en, a_addr, a_din); end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_req_valid = 4'b0001; bus.rd_req_addr = 16'h0003;
    #1;
    checks++; if (bus.rd_req_ready !== 4'b0001 || b_en !== 1'b1 || b_addr !== 4'd3) begin
      failures++; $display("FAIL rd_grant got rdy=%0b en=%0b addr=%0d exp rdy=0001 en=1 addr=3", bus.rd_req_ready, b_en, b_addr); end
    @(posedge clk); #1;
    checks++; if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_id !== 2'd0) begin
      failures++; $display("FAIL rd_resp_vid got v=%0b id=%0d exp v=1 id=0", bus.rd_resp_valid, bus.rd_resp_id); end
    checks++; if (bus.rd_resp_data !== 50'h1234 || bus.rd_resp_hit !== 1'b1) begin
      failures++; $display("FAIL rd_resp_data got data=%0h hit=%0b exp data=1234 hit=1", bus.rd_resp_data, bus.rd_resp_hit); end
    checks++; if (bitmap !== 16'h0008) begin failures++; $display("FAIL wr_bitmap got=%0h exp=0008", bitmap); end
    @(negedge clk);
    bus.rd_req_valid = 4'b0;
  endtask

  task automatic test_clear();
    bus.clr_valid = 1'b1; bus.clr_addr = 4'd3;
    @(negedge clk);
    bus.clr_valid = 1'b0;
    bus.rd_req_valid = 4'b0001; bus.rd_req_addr = 16'h0003;
    @(posedge clk); #1;
    checks++; if (bus.rd_resp_hit !== 1'b0 || bus.rd_resp_data !== 50'h1234) begin
      failures++; $display("FAIL clr_read got hit=%0b data=%0h exp hit=0 data=1234", bus.rd_resp_hit, bus.rd_resp_data); end
    checks++; if (bitmap !== 16'h0) begin failures++; $display("FAIL clr_bitmap got=%0h exp=0", bitmap); end
    @(negedge clk);
    bus.rd_req_valid = 4'b0;
  endtask

  // Pointer sits at 0 after the previous reads, so rotation starts at client 1.
  task automatic test_back_to_back();
    logic [1:0]  exp_g;
    logic [49:0] exp_d;
    bus.rd_req_valid = 4'b1111; bus.rd_req_addr = 16'h3210;
    for (int k = 0; k < 8; k++) begin
      exp_g = 2'(k + 1);
      exp_d = (exp_g == 2'd3) ? 50'h1234 : 50'h0;
      #1;
      checks++; if (bus.rd_req_ready !== (4'b0001 << exp_g)) begin
        failures++; $display("FAIL rr_grant[%0d] got=%0b exp=%0b", k, bus.rd_req_ready, 4'b0001 << exp_g); end
      @(posedge clk); #1;
      checks++; if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_id !== exp_g || bus.rd_resp_data !== exp_d || bus.rd_resp_hit !== 1'b0) begin
        failures++; $display("FAIL rr_resp[%0d] got v=%0b id=%0d data=%0h hit=%0b exp v=1 id=%0d data=%0h hit=0",
                             k, bus.rd_resp_valid, bus.rd_resp_id, bus.rd_resp_data, bus.rd_resp_hit, exp_g, exp_d); end
      @(negedge clk);
    end
    bus.rd_req_valid = 4'b0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 50'hABC;
    bus.rd_req_valid = 4'b0100; bus.rd_req_addr = 16'h0500;
    #1;
    checks++; if (bus.rd_req_ready !== 4'b0100) begin failures++; $display("FAIL byp_grant got=%0b exp=0100", bus.rd_req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.rd_resp_id !== 2'd2 || bus.rd_resp_data !== 50'hABC || bus.rd_resp_hit !== 1'b1) begin
      failures++; $display("FAIL byp_resp got id=%0d data=%0h hit=%0b exp id=2 data=abc hit=1", bus.rd_resp_id, bus.rd_resp_data, bus.rd_resp_hit); end
    @(negedge clk);
    bus.wr_data = 50'h777;
    bus.clr_valid = 1'b1; bus.clr_addr = 4'd5;
    bus.rd_req_valid = 4'b0010; bus.rd_req_addr = 16'h0050;
    @(posedge clk); #1;
    checks++; if (bitmap !== 16'h0020) begin failures++; $display("FAIL set_wins_bitmap got=%0h exp=0020", bitmap); end
    checks++; if (bus.rd_resp_id !== 2'd1 || bus.rd_resp_data !== 50'h777 || bus.rd_resp_hit !== 1'b1) begin
      failures++; $display("FAIL set_wins_resp got id=%0d data=%0h hit=%0b exp id=1 data=777 hit=1", bus.rd_resp_id, bus.rd_resp_data, bus.rd_resp_hit); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.rd_req_valid = 4'b1000; bus.rd_req_addr = 16'h5000;
    @(posedge clk); #1;
    checks++; if (bus.rd_resp_valid !== 1'b1 || bus.rd_resp_id !== 2'd3) begin
      failures++; $display("FAIL mid_pre_resp got v=%0b id=%0d exp v=1 id=3", bus.rd_resp_valid, bus.rd_resp_id); end
    rstn = 1'b0;
    bus.rd_req_valid = 4'b0;
    #1;
    checks++; if (bus.rd_resp_valid !== 1'b0 || bitmap !== 16'h0) begin
      failures++; $display("FAIL mid_reset got v=%0b bitmap=%0h exp v=0 bitmap=0", bus.rd_resp_valid, bitmap); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rd_resp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_resp got=%0b exp=0", bus.rd_resp_valid); end
    @(negedge clk);
    bus.rd_req_valid = 4'b1111; bus.rd_req_addr = 16'h5555;
    #1;
    checks++; if (bus.rd_req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant got=%0b exp=0001", bus.rd_req_ready); end
    @(posedge clk); #1;
    checks++; if (bus.rd_resp_id !== 2'd0 || bus.rd_resp_hit !== 1'b0 || bus.rd_resp_data !== 50'h777) begin
      failures++; $display("FAIL mid_resp got id=%0d hit=%0b data=%0h exp id=0 hit=0 data=777", bus.rd_resp_id, bus.rd_resp_hit, bus.rd_resp_data); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus2.wr_valid = 1'b1; bus2.wr_addr = 4'd13; bus2.wr_data = 50'h99;
    bus2.rd_req_valid = 4'b0001; bus2.rd_req_addr = 16'h000D;
    #1;
    checks++; if (a_en2 !== 1'b0 || b_en2 !== 1'b0 || bus2.rd_req_ready !== 4'b0001) begin
      failures++; $display("FAIL oor_ports got a_en=%0b b_en=%0b rdy=%0b exp 0 0 0001", a_en2, b_en2, bus2.rd_req_ready); end
    @(posedge clk); #1;
    checks++; if (bus2.rd_resp_valid !== 1'b1 || bus2.rd_resp_hit !== 1'b0 || bus2.rd_resp_data !== 50'h0) begin
      failures++; $display("FAIL oor_resp got v=%0b hit=%0b data=%0h exp v=1 hit=0 data=0", bus2.rd_resp_valid, bus2.rd_resp_hit, bus2.rd_resp_data); end
    checks++; if (bitmap2 !== 12'h0) begin failures++; $display("FAIL oor_bitmap got=%0h exp=0", bitmap2); end
    @(negedge clk);
    bus2.wr_addr = 4'd11;
    bus2.rd_req_valid = 4'b0;
    #1;
    checks++; if (a_en2 !== 1'b1 || a_addr2 !== 4'd11) begin failures++; $display("FAIL top_slot_porta got en=%0b addr=%0d exp en=1 addr=11", a_en2, a_addr2); end
    @(posedge clk); #1;
    checks++; if (bitmap2 !== 12'h800) begin failures++; $display("FAIL top_slot_bitmap got=%0h exp=800", bitmap2); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    mem_clear = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_write_read();
    test_clear();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a task stalls; counted as a failure before ending.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
